// File: rtl/instruction_fetch.sv
// Instruction fetch unit: drives a synchronous word-addressed ROM, holds the
// fetched word for decode under a valid/ready handshake, supports jump and halt.
module instruction_fetch #(
    parameter logic [4:0]  RESET_PC = 5'd0,
    parameter int unsigned ROM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        halt,
    input  logic        jump,
    input  logic [4:0]  jump_target,
    output logic [4:0]  rom_address,
    output logic        rom_chip_select,
    input  logic [31:0] rom_data,
    output logic [31:0] instr,
    output logic [4:0]  instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {IDLE, ADDR, HOLD, HALTED} state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(ROM_WAIT);

    state_t     state;
    state_t     next_state;
    logic [4:0] pc;
    logic [2:0] count;
    logic       transfer;
    logic       capture;

    assign transfer    = (state == HOLD) && instr_valid && instr_ready;
    assign capture     = (state == ADDR) && !jump && (count == 3'd1);
    assign rom_address = pc;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (halt)        next_state = HALTED;
                else if (enable) next_state = ADDR;
            end
            ADDR: begin
                if (capture) next_state = HOLD;
            end
            HOLD: begin
                // halt only matters when the held word actually leaves
                if (transfer)  next_state = halt ? HALTED : (enable ? ADDR : IDLE);
                else if (jump) next_state = enable ? ADDR : IDLE;
            end
            HALTED: next_state = HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            count           <= 3'd0;
            rom_chip_select <= 1'b0;
            instr           <= 32'd0;
            instr_pc        <= 5'd0;
            instr_valid     <= 1'b0;
        end else begin
            state           <= next_state;
            rom_chip_select <= (next_state == ADDR);

            // a jump inside ADDR restarts the wait from the new address
            if ((next_state == ADDR) && ((state != ADDR) || jump))
                count <= WAIT_LOAD;
            else if (state == ADDR)
                count <= count - 3'd1;

            if (jump && (state != HALTED))
                pc <= jump_target;
            else if (capture)
                pc <= pc + 5'd1;

            if (capture) begin
                instr       <= rom_data;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
            end else if ((state == HOLD) && (transfer || jump)) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule
